// File: rtl/fft_frame_sequencer.sv
// Feeds the streaming FFT core: one config word after reset, offset-binary audio to complex beats framed by tlast.
// Latency: audio strobe at N gives a valid beat at N+1. Backpressure: the held beat is kept stable while tready is low; extra samples are dropped and counted.
module fft_frame_sequencer #(
    parameter int                      FFT_SIZE     = 1024,
    parameter int                      CONFIG_WIDTH = 8,
    parameter logic [CONFIG_WIDTH-1:0] CONFIG_VALUE = 8'h01
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic [7:0]                    audio_in,
    input  logic                          audio_valid_in,
    output logic [CONFIG_WIDTH-1:0]       cfg_tdata_out,
    output logic                          cfg_tvalid_out,
    input  logic                          cfg_tready_in,
    output logic [31:0]                   fft_tdata_out,
    output logic                          fft_tvalid_out,
    output logic                          fft_tlast_out,
    input  logic                          fft_tready_in,
    input  logic                          fft_out_tvalid_in,
    input  logic                          fft_out_tlast_in,
    output logic                          fft_out_tready_out,
    output logic [$clog2(FFT_SIZE)-1:0]   bin_index_out,
    output logic                          frame_done_out,
    output logic                          tlast_error_out,
    output logic [15:0]                   overflow_count_out
);

    localparam int IW = $clog2(FFT_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        S_CFG,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t        state_q, state_d;
    logic          hold_vld_q, hold_vld_d;
    logic [15:0]   hold_re_q, hold_re_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   ovf_q, ovf_d;
    logic [IW-1:0] bin_q, bin_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [7:0]    centered;
    logic          beat_acc;
    logic          idx_last;
    logic          frame_end_idle;
    logic          out_acc;
    logic          bin_last;

    assign centered       = audio_in - 8'd128;
    assign beat_acc       = hold_vld_q && fft_tready_in;
    assign idx_last       = (idx_q == LAST_IDX);
    // Last beat of a frame leaves for WAIT when disabled; a sample arriving then is discarded.
    assign frame_end_idle = beat_acc && idx_last && !enable_in;
    assign out_acc        = fft_out_tvalid_in && (state_q != S_CFG);
    assign bin_last       = (bin_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        hold_vld_d = hold_vld_q;
        hold_re_d  = hold_re_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        bin_d      = bin_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_CFG: begin
                if (cfg_tready_in) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (enable_in) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (beat_acc) begin
                    hold_vld_d = 1'b0;
                    idx_d      = idx_last ? '0 : idx_q + 1'b1;
                    if (frame_end_idle) begin
                        state_d = S_WAIT;
                    end
                end
                if (audio_valid_in) begin
                    if (!hold_vld_q || (beat_acc && !frame_end_idle)) begin
                        hold_vld_d = 1'b1;
                        hold_re_d  = {{8{centered[7]}}, centered};
                    end else if (!beat_acc && ovf_q != 16'hFFFF) begin
                        ovf_d = ovf_q + 16'd1;
                    end
                end
            end
            default: state_d = S_CFG;
        endcase

        // Any tlast/index disagreement realigns the bin counter to the next frame start.
        if (out_acc) begin
            if (fft_out_tlast_in && bin_last) begin
                done_d = 1'b1;
                bin_d  = '0;
            end else if (fft_out_tlast_in || bin_last) begin
                err_d  = 1'b1;
                bin_d  = '0;
            end else begin
                bin_d  = bin_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_CFG;
            hold_vld_q <= 1'b0;
            hold_re_q  <= '0;
            idx_q      <= '0;
            ovf_q      <= '0;
            bin_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            hold_re_q  <= hold_re_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
            bin_q      <= bin_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cfg_tvalid_out     = (state_q == S_CFG);
    assign cfg_tdata_out      = cfg_tvalid_out ? CONFIG_VALUE : '0;
    assign fft_tdata_out      = {16'h0000, hold_re_q};
    assign fft_tvalid_out     = hold_vld_q;
    assign fft_tlast_out      = hold_vld_q && idx_last;
    assign fft_out_tready_out = (state_q != S_CFG);
    assign bin_index_out      = bin_q;
    assign frame_done_out     = done_q;
    assign tlast_error_out    = err_q;
    assign overflow_count_out = ovf_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with an 8-point frame.
module tb_fft_frame_sequencer;

    localparam int N = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic [7:0]  audio_in;
    logic        audio_valid_in;
    logic [7:0]  cfg_tdata_out;
    logic        cfg_tvalid_out;
    logic        cfg_tready_in;
    logic [31:0] fft_tdata_out;
    logic        fft_tvalid_out;
    logic        fft_tlast_out;
    logic        fft_tready_in;
    logic        fft_out_tvalid_in;
    logic        fft_out_tlast_in;
    logic        fft_out_tready_out;
    logic [2:0]  bin_index_out;
    logic        frame_done_out;
    logic        tlast_error_out;
    logic [15:0] overflow_count_out;

    always #5 clk_in = ~clk_in;

    fft_frame_sequencer #(
        .FFT_SIZE     (N),
        .CONFIG_WIDTH (8),
        .CONFIG_VALUE (8'h01)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .enable_in          (enable_in),
        .audio_in           (audio_in),
        .audio_valid_in     (audio_valid_in),
        .cfg_tdata_out      (cfg_tdata_out),
        .cfg_tvalid_out     (cfg_tvalid_out),
        .cfg_tready_in      (cfg_tready_in),
        .fft_tdata_out      (fft_tdata_out),
        .fft_tvalid_out     (fft_tvalid_out),
        .fft_tlast_out      (fft_tlast_out),
        .fft_tready_in      (fft_tready_in),
        .fft_out_tvalid_in  (fft_out_tvalid_in),
        .fft_out_tlast_in   (fft_out_tlast_in),
        .fft_out_tready_out (fft_out_tready_out),
        .bin_index_out      (bin_index_out),
        .frame_done_out     (frame_done_out),
        .tlast_error_out    (tlast_error_out),
        .overflow_count_out (overflow_count_out)
    );

    int          total = 0;
    int          bad = 0;
    int          sb_idx = 0;
    int          cfg_hs = 0;
    int          done_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Expected beat: {tlast, imag=0, real = sample - 128}
    task automatic push_beat(input logic [7:0] a);
        int          r;
        logic [15:0] re;
        r  = int'(a) - 128;
        re = r[15:0];
        exp_q.push_back({(sb_idx == N - 1), 16'h0000, re});
        sb_idx = (sb_idx + 1) % N;
    endtask

    task automatic send(input logic [7:0] a);
        audio_in       = a;
        audio_valid_in = 1'b1;
        push_beat(a);
        tick;
        audio_valid_in = 1'b0;
    endtask

    always @(negedge clk_in) begin
        if (cfg_tvalid_out && cfg_tready_in) cfg_hs++;
        if (frame_done_out) done_cnt++;
        if (!rst_in && fft_tvalid_out && fft_tready_in) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", fft_tvalid_out, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("beat", {fft_tlast_out, fft_tdata_out}, mon_exp);
            end
        end
    end

    initial begin
        rst_in = 1'b1; enable_in = 1'b0; audio_in = '0; audio_valid_in = 1'b0;
        cfg_tready_in = 1'b0; fft_tready_in = 1'b1;
        fft_out_tvalid_in = 1'b0; fft_out_tlast_in = 1'b0;
        tick; tick;
        rst_in = 1'b0;

        chk("rst_cfg_vld", cfg_tvalid_out, 1);
        chk("rst_cfg_dat", cfg_tdata_out, 8'h01);
        chk("rst_tvalid", fft_tvalid_out, 0);
        chk("rst_tlast", fft_tlast_out, 0);
        chk("rst_out_rdy", fft_out_tready_out, 0);
        chk("rst_bin", bin_index_out, 0);
        chk("rst_done", frame_done_out, 0);
        chk("rst_err", tlast_error_out, 0);
        chk("rst_ovf", overflow_count_out, 0);

        for (int i = 0; i < 5; i++) begin
            tick;
            chk("cfg_hold_vld", cfg_tvalid_out, 1);
            chk("cfg_hold_dat", cfg_tdata_out, 8'h01);
        end
        cfg_tready_in = 1'b1;
        tick;
        chk("cfg_drop", cfg_tvalid_out, 0);
        chk("out_rdy_wait", fft_out_tready_out, 1);
        tick;
        chk("cfg_hs_once", cfg_hs, 1);

        audio_in = 8'h55; audio_valid_in = 1'b1;
        tick;
        audio_valid_in = 1'b0;
        chk("wait_discard", fft_tvalid_out, 0);
        chk("wait_no_ovf", overflow_count_out, 0);

        enable_in = 1'b1;
        tick;
        for (int i = 0; i < N; i++) send(8'(128 + i));
        tick;
        chk("frame1_drained", exp_q.size(), 0);

        send(8'h00);
        send(8'hFF);
        tick;
        chk("extremes_drained", exp_q.size(), 0);

        fft_tready_in = 1'b0;
        send(8'h90);
        audio_in = 8'h11; audio_valid_in = 1'b1;
        tick;
        chk("bp_hold1", fft_tdata_out, 32'h0000_0010);
        audio_in = 8'h22;
        tick;
        audio_valid_in = 1'b0;
        chk("bp_hold2", fft_tdata_out, 32'h0000_0010);
        tick;
        chk("bp_hold3", fft_tdata_out, 32'h0000_0010);
        chk("bp_vld", fft_tvalid_out, 1);
        chk("ovf_two", overflow_count_out, 2);
        fft_tready_in = 1'b1;
        tick;
        chk("bp_drained", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i));
        tick;
        chk("frame2_drained", exp_q.size(), 0);

        for (int i = 0; i < N; i++) begin
            chk("bin_idx", bin_index_out, i);
            fft_out_tvalid_in = 1'b1;
            fft_out_tlast_in  = (i == N - 1);
            tick;
        end
        fft_out_tvalid_in = 1'b0; fft_out_tlast_in = 1'b0;
        chk("done_pulse", frame_done_out, 1);
        chk("bin_wrap", bin_index_out, 0);
        tick;
        chk("done_low", frame_done_out, 0);
        chk("done_once", done_cnt, 1);
        chk("no_err_yet", tlast_error_out, 0);

        for (int i = 0; i < 6; i++) begin
            fft_out_tvalid_in = 1'b1;
            fft_out_tlast_in  = (i == 5);
            tick;
        end
        fft_out_tvalid_in = 1'b0; fft_out_tlast_in = 1'b0;
        chk("early_tlast_err", tlast_error_out, 1);
        chk("early_tlast_bin", bin_index_out, 0);
        tick; tick;
        chk("err_sticky", tlast_error_out, 1);
        fft_out_tvalid_in = 1'b1;
        tick;
        fft_out_tvalid_in = 1'b0;
        chk("bin_after_resync", bin_index_out, 1);
        chk("err_still", tlast_error_out, 1);
        chk("no_done_on_err", done_cnt, 1);

        for (int i = 0; i < 4; i++) send(8'(8'h81 + i));
        tick;
        cfg_tready_in = 1'b0;
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
        sb_idx = 0;
        chk("mid_rst_q", exp_q.size(), 0);
        chk("mid_rst_cfg", cfg_tvalid_out, 1);
        chk("mid_rst_tvalid", fft_tvalid_out, 0);
        chk("mid_rst_ovf", overflow_count_out, 0);
        chk("mid_rst_err", tlast_error_out, 0);
        chk("mid_rst_bin", bin_index_out, 0);
        cfg_tready_in = 1'b1;
        tick;
        chk("cfg_resent", cfg_hs, 2);
        chk("cfg_resent_drop", cfg_tvalid_out, 0);
        tick;
        for (int i = 0; i < N; i++) begin
            if (i == 3) enable_in = 1'b0;
            send(8'(8'h40 + 3 * i));
        end
        tick;
        chk("frame3_drained", exp_q.size(), 0);
        tick;
        chk("idle_tvalid", fft_tvalid_out, 0);
        audio_in = 8'h77; audio_valid_in = 1'b1;
        tick;
        audio_valid_in = 1'b0;
        tick;
        chk("idle_discard", fft_tvalid_out, 0);
        chk("idle_no_ovf", overflow_count_out, 0);
        chk("final_q", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Controller sitting between the audio sample source and the streaming FFT core (AXI4-Stream config, input and output channels). Sends the FFT configuration word once after reset and converts 8-bit offset-binary audio samples into 32-bit complex FFT input beats. Frames FFT_SIZE beats with tlast and honours core backpressure. Also consumes the FFT output handshake to track bin index, pulse frame completion and flag framing errors.

Parameters:
FFT_SIZE, 1024, points per transform; power of two, 8..65536
CONFIG_WIDTH, 8, width of the FFT config tdata
CONFIG_VALUE, 8'h01, config word sent after reset (bit0 = forward transform)

Ports:
clk_in  input  1  system clock, 100 MHz
rst_in  input  1  synchronous active-high reset
enable_in  input  1  allow new frames to start
audio_in  input  8  unsigned offset-binary audio sample
audio_valid_in  input  1  one-cycle strobe, audio_in valid
cfg_tdata_out  output  CONFIG_WIDTH  FFT s_axis_config_tdata
cfg_tvalid_out  output  1  FFT s_axis_config_tvalid
cfg_tready_in  input  1  FFT s_axis_config_tready
fft_tdata_out  output  32  FFT s_axis_data_tdata; [15:0] real, [31:16] imag
fft_tvalid_out  output  1  FFT s_axis_data_tvalid
fft_tlast_out  output  1  FFT s_axis_data_tlast
fft_tready_in  input  1  FFT s_axis_data_tready
fft_out_tvalid_in  input  1  FFT m_axis_data_tvalid
fft_out_tlast_in  input  1  FFT m_axis_data_tlast
fft_out_tready_out  output  1  FFT m_axis_data_tready
bin_index_out  output  $clog2(FFT_SIZE)  index of current output bin
frame_done_out  output  1  one-cycle pulse after last bin accepted
tlast_error_out  output  1  sticky output framing error
overflow_count_out  output  16  dropped samples, saturating

Behaviour:
- Reset (rst_in=1 at a clock edge): state CFG. All outputs 0 except cfg_tvalid_out=1 and cfg_tdata_out=CONFIG_VALUE from the first cycle after reset. Sample index 0, holding register empty. Reset mid-frame discards the partial frame; config is re-sent.
- States: CFG -> WAIT -> STREAM -> WAIT ...
- CFG: hold cfg_tvalid_out=1 and the config word stable until cfg_tvalid_out && cfg_tready_in. Next cycle cfg_tvalid_out=0, go to WAIT. Audio is ignored in CFG (not counted as overflow). fft_out_tready_out=0 in CFG, 1 in all other states.
- WAIT (sample index 0): if enable_in=1, go to STREAM. Audio arriving in WAIT is discarded, not counted.
- STREAM: audio_valid_in at cycle N loads the holding register; fft_tvalid_out=1 from N+1.
- Conversion: real = sign-extend(audio_in - 8'd128) to 16 bits; imag = 0.
- Handshake: beat accepted when fft_tvalid_out && fft_tready_in. While tvalid && !tready, tdata and tlast stay stable and tvalid never drops.
- fft_tlast_out = (sample index == FFT_SIZE-1). On acceptance, index increments and wraps to 0 after FFT_SIZE-1. At the wrap, go to WAIT if enable_in=0, else stay in STREAM. enable_in low mid-frame does not stop the frame.
- Overflow: audio_valid_in while the holding register is full and not accepted this cycle drops the new sample; overflow_count_out += 1, saturating at 16'hFFFF. If the held beat is accepted in the same cycle, the new sample loads with no drop and tvalid stays 1.
- Output side: bin_index_out increments on each fft_out_tvalid_in && fft_out_tready_out and wraps after FFT_SIZE-1.
  - Accepted beat with tlast and index FFT_SIZE-1: frame_done_out=1 next cycle for exactly one cycle.
  - tlast at any other index, or index FFT_SIZE-1 without tlast: tlast_error_out set, sticky until reset, and bin_index_out resyncs to 0.

Test Plan:
- Reset; cfg_tready_in=0 for 5 cycles then 1 -> cfg_tvalid_out=1 with 8'h01 throughout, exactly one handshake, cfg_tvalid_out=0 the cycle after.
- FFT_SIZE=8, enable_in=1, tready=1, audio 128..135 one per cycle -> tdata 0x00000000..0x00000007, tlast only on the 8th beat, index wraps to 0.
- audio 0x00 -> tdata 0x0000FF80; audio 0xFF -> tdata 0x0000007F.
- fft_tready_in=0 for 3 cycles while the holding register is full and 2 audio strobes arrive -> held tdata stable, overflow_count_out=2, held sample delivered intact when tready returns.
- Output burst of 8 beats with tlast at index 7 -> frame_done_out pulses once. Next burst with tlast at index 5 -> tlast_error_out=1 and stays set; bin_index_out=0 after that beat.
- rst_in asserted at sample index 4; enable_in dropped mid-frame -> after reset, index 0, config re-sent. Disabled frame finishes all 8 beats, then WAIT with tvalid=0.
